// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared types and constants for the 4x4 keypad scanner:
//   FSM state enumeration, column drive patterns, frame classification
//   and a helper that classifies a 16-bit frame in one call.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_e;

   typedef enum logic [1:0] {
      FR_EMPTY  = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } frame_class_e;

   typedef struct packed {
      frame_class_e cls;
      logic [3:0]   code;
   } frame_info_t;

   // Active-low one-hot column drive, indexed by column number.
   localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Classify a frame and, for a single press, report its bit position.
   function automatic frame_info_t frame_eval(input logic [15:0] f);
      frame_info_t fi;
      int          n;
      n       = 0;
      fi.code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (f[i]) begin
            n       = n + 1;
            fi.code = 4'(i);
         end
      end
      if (n == 0)      fi.cls = FR_EMPTY;
      else if (n == 1) fi.cls = FR_SINGLE;
      else             fi.cls = FR_MULTI;
      return fi;
   endfunction

endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// scan_timer
//   Prescaler counting 0..SCAN_DIV-1; the terminal count is the tick.
//   The column index advances 0..3 on every tick.
//   Ports: clk, reset_n (sync, active-low), tick (1 cycle per SCAN_DIV),
//          col_idx (currently driven column).
module scan_timer #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       tick,
   output logic [1:0] col_idx
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] presc;

   assign tick = (presc == PW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         presc   <= '0;
         col_idx <= 2'd0;
      end else if (tick) begin
         presc   <= '0;
         col_idx <= col_idx + 2'd1;
      end else begin
         presc   <= presc + PW'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low keypad one column per SCAN_DIV cycles, builds a
//   16-bit frame per full scan and debounces single presses over
//   DEBOUNCE_CNT frames. Only one key is reported at a time (no rollover).
//   Ports: clk, reset_n (sync, active-low), rows (async, active-low),
//          cols (active-low one-hot drive), key_code (row*4+col of the last
//          accepted key), key_valid (1-cycle accept pulse), key_held.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

   logic        tick;
   logic [1:0]  col_idx;
   logic [3:0]  row_s1, row_s2;
   logic [15:0] frame_acc, frame_now, col_bits;
   logic        frame_end;
   frame_info_t fi;
   logic        has_cand;

   kp_state_e   state, state_nxt;
   logic [3:0]  cand, cand_nxt;
   logic [3:0]  cnt, cnt_nxt, cnt_inc;
   logic        accept;

   scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .col_idx (col_idx)
   );

   // Two-flop synchronizer; idle (all released) after reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= rows;
         row_s2 <= row_s1;
      end
   end

   // Bits pressed in the active column, placed at row*4+col.
   always_comb begin
      col_bits = '0;
      for (int r = 0; r < 4; r++)
         col_bits[{r[1:0], col_idx}] = ~row_s2[r];
   end

   // The column-3 sample is folded in combinationally so the frame is
   // evaluated on the same cycle it completes.
   assign frame_now = frame_acc | (tick ? col_bits : 16'h0000);
   assign frame_end = tick && (col_idx == 2'd3);
   assign fi        = frame_eval(frame_now);
   assign has_cand  = frame_now[cand];
   assign cnt_inc   = cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (!reset_n)       frame_acc <= '0;
      else if (frame_end) frame_acc <= '0;
      else if (tick)      frame_acc <= frame_now;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cand      <= 4'h0;
         cnt       <= 4'h0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         cnt       <= cnt_nxt;
         key_valid <= accept;
         if (accept) key_code <= cand_nxt;
      end
   end

   // Next-state logic; everything moves only at frame-end.
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      if (frame_end) begin
         unique case (state)
            ST_IDLE: begin
               if (fi.cls == FR_SINGLE) begin
                  cand_nxt = fi.code;
                  if (DB == 4'd1) begin
                     state_nxt = ST_PRESSED;
                     cnt_nxt   = 4'd0;
                     accept    = 1'b1;
                  end else begin
                     state_nxt = ST_DEBOUNCE;
                     cnt_nxt   = 4'd1;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (fi.cls == FR_SINGLE) begin
                  if (fi.code == cand) begin
                     if (cnt_inc == DB) begin
                        state_nxt = ST_PRESSED;
                        cnt_nxt   = 4'd0;
                        accept    = 1'b1;
                     end else begin
                        cnt_nxt = cnt_inc;
                     end
                  end else begin
                     cand_nxt = fi.code;
                     cnt_nxt  = 4'd1;
                  end
               end else begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = 4'd0;
               end
            end
            ST_PRESSED: begin
               if (!has_cand) begin
                  if (fi.cls == FR_EMPTY) begin
                     // A single empty frame already completes release when
                     // only one agreeing frame is required.
                     state_nxt = (DB == 4'd1) ? ST_IDLE : ST_RELEASE;
                     cnt_nxt   = (DB == 4'd1) ? 4'd0 : 4'd1;
                  end else begin
                     state_nxt = ST_RELEASE;
                     cnt_nxt   = 4'd0;
                  end
               end
            end
            ST_RELEASE: begin
               if (has_cand) begin
                  state_nxt = ST_PRESSED;
                  cnt_nxt   = 4'd0;
               end else if (fi.cls == FR_EMPTY) begin
                  if (cnt_inc >= DB) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = 4'd0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  cnt_nxt = 4'd0;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      cols     = COL_DRIVE[col_idx];
      key_held = (state == ST_PRESSED) || (state == ST_RELEASE);
   end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 2;
   localparam int FRAME = 4 * SD;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys = 16'h0000;

   int total = 0;
   int bad   = 0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rows      (rows),
      .cols      (cols),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low while its column is driven.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!cols[c] && keys[r*4+c]) rows[r] = 1'b0;
   end

   // Reference model, one step per scanned frame: a key is accepted after DB
   // consecutive frames showing only that key while nothing is held; a held
   // key is dropped after DB consecutive empty frames.
   logic       m_held, m_valid;
   logic [3:0] m_code;
   int         cand_key, run_single, run_empty;

   task automatic model_reset();
      m_held = 0; m_valid = 0; m_code = 4'h0;
      cand_key = -1; run_single = 0; run_empty = 0;
   endtask

   task automatic model_frame(input logic [15:0] f);
      int n, code;
      n = $countones(f);
      code = 0;
      for (int i = 0; i < 16; i++) if (f[i]) code = i;
      m_valid = 0;
      if (!m_held) begin
         if (n == 1) begin
            if (run_single > 0 && code == cand_key) run_single++;
            else begin cand_key = code; run_single = 1; end
            if (run_single >= DB) begin
               m_held = 1; m_valid = 1; m_code = 4'(cand_key);
               run_single = 0; run_empty = 0;
            end
         end else run_single = 0;
      end else begin
         if (n == 0) begin
            run_empty++;
            if (run_empty >= DB) begin m_held = 0; run_empty = 0; end
         end else run_empty = 0;
      end
   endtask

   // Observations from the last frame
   logic       e_valid, e_held, o_valid, o_held;
   logic [3:0] e_code, o_code;
   int         o_extra, exp_pulses, obs_pulses;
   logic [15:0] seq[$];

   task automatic add(input int n, input logic [15:0] m);
      repeat (n) seq.push_back(m);
   endtask

   // Reset for 3 edges; returns at the negedge of the first cycle after
   // release (prescaler 0, column 0).
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      keys = 16'h0000;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      exp_pulses = 0;
      obs_pulses = 0;
   endtask

   // Entered at the negedge of a frame's first cycle: sample the outputs
   // that reflect the previous frame, apply this frame's keys, run 16 cycles.
   task automatic run_frame(input logic [15:0] k);
      e_valid = m_valid; e_held = m_held; e_code = m_code;
      o_valid = key_valid; o_held = key_held; o_code = key_code;
      exp_pulses += int'(e_valid);
      obs_pulses += int'(o_valid);
      keys = k;
      model_frame(k);
      o_extra = 0;
      repeat (FRAME - 1) begin
         @(negedge clk);
         if (key_valid) o_extra++;
      end
      obs_pulses += o_extra;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
         bad++;
         $display("FAIL reset_outputs valid=%b held=%b code=%h want 0/0/0", key_valid, key_held, key_code);
      end
      for (int i = 0; i < 20; i++) begin
         logic [3:0] want;
         want = ~(4'b0001 << ((i / SD) % 4));
         total++;
         if (cols !== want) begin
            bad++;
            $display("FAIL reset_cols cycle=%0d got=%b want=%b", i, cols, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_press();
      seq.delete();
      add(4, 16'h0200);
      add(4, 16'h0000);
      do_reset();
      foreach (seq[i]) begin
         run_frame(seq[i]);
         total++;
         if (o_valid !== e_valid || o_extra != 0) begin
            bad++; $display("FAIL press_valid f=%0d got=%b+%0d want=%b+0", i, o_valid, o_extra, e_valid);
         end
         total++;
         if (o_held !== e_held) begin bad++; $display("FAIL press_held f=%0d got=%b want=%b", i, o_held, e_held); end
         total++;
         if (o_code !== e_code) begin bad++; $display("FAIL press_code f=%0d got=%h want=%h", i, o_code, e_code); end
      end
      total++;
      if (obs_pulses != 1 || key_code !== 4'h9) begin
         bad++; $display("FAIL press_once pulses=%0d code=%h want 1 and 9", obs_pulses, key_code);
      end
   endtask

   task automatic test_bounce();
      seq.delete();
      for (int j = 0; j < 5; j++) begin add(1, 16'h0008); add(1, 16'h0000); end
      add(1, 16'h0000);
      do_reset();
      foreach (seq[i]) begin
         run_frame(seq[i]);
         total++;
         if (o_valid !== e_valid || o_extra != 0) begin
            bad++; $display("FAIL bounce_valid f=%0d got=%b+%0d want=%b+0", i, o_valid, o_extra, e_valid);
         end
         total++;
         if (o_held !== e_held) begin bad++; $display("FAIL bounce_held f=%0d got=%b want=%b", i, o_held, e_held); end
      end
      total++;
      if (obs_pulses != 0) begin bad++; $display("FAIL bounce_pulses got=%0d want=0", obs_pulses); end
   endtask

   task automatic test_multi();
      seq.delete();
      add(4, 16'h0081);
      add(3, 16'h0001);
      add(3, 16'h0000);
      do_reset();
      foreach (seq[i]) begin
         run_frame(seq[i]);
         total++;
         if (o_valid !== e_valid || o_extra != 0) begin
            bad++; $display("FAIL multi_valid f=%0d got=%b+%0d want=%b+0", i, o_valid, o_extra, e_valid);
         end
         total++;
         if (o_held !== e_held) begin bad++; $display("FAIL multi_held f=%0d got=%b want=%b", i, o_held, e_held); end
         total++;
         if (o_code !== e_code) begin bad++; $display("FAIL multi_code f=%0d got=%h want=%h", i, o_code, e_code); end
      end
      total++;
      if (obs_pulses != exp_pulses || exp_pulses != 1) begin
         bad++; $display("FAIL multi_pulses got=%0d want=%0d", obs_pulses, exp_pulses);
      end
   endtask

   task automatic test_rollover();
      seq.delete();
      add(3, 16'h4000);
      add(2, 16'h4020);
      add(2, 16'h0000);
      add(3, 16'h0020);
      add(2, 16'h0000);
      do_reset();
      foreach (seq[i]) begin
         run_frame(seq[i]);
         total++;
         if (o_valid !== e_valid || o_extra != 0) begin
            bad++; $display("FAIL rollover_valid f=%0d got=%b+%0d want=%b+0", i, o_valid, o_extra, e_valid);
         end
         total++;
         if (o_held !== e_held) begin bad++; $display("FAIL rollover_held f=%0d got=%b want=%b", i, o_held, e_held); end
         total++;
         if (o_code !== e_code) begin bad++; $display("FAIL rollover_code f=%0d got=%h want=%h", i, o_code, e_code); end
      end
      total++;
      if (obs_pulses != 2 || key_code !== 4'h5) begin
         bad++; $display("FAIL rollover_pulses pulses=%0d code=%h want 2 and 5", obs_pulses, key_code);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      do_reset();
      run_frame(16'h0010);
      pulses = int'(key_valid);
      repeat (6) begin @(negedge clk); pulses += int'(key_valid); end
      reset_n = 1'b0;
      @(negedge clk);
      total++;
      if (cols !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0) begin
         bad++; $display("FAIL midreset_state cols=%b held=%b valid=%b want 1110/0/0", cols, key_held, key_valid);
      end
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_frame(16'h0000);
         pulses += int'(o_valid) + o_extra;
         total++;
         if (o_held !== 1'b0) begin bad++; $display("FAIL midreset_held f=%0d got=%b want=0", i, o_held); end
      end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL midreset_pulses got=%0d want=0", pulses); end
   endtask

   task automatic test_random();
      seq.delete();
      while (seq.size() < 60) begin
         int t, len;
         logic [15:0] m;
         t = $urandom_range(0, 9);
         len = $urandom_range(1, 4);
         if (t < 4) m = 16'h0000;
         else if (t < 9) begin
            m = 16'h0000;
            m[$urandom_range(0, 2) * 5] = 1'b1;
         end else begin
            m = 16'h0000;
            m[$urandom_range(0, 7)] = 1'b1;
            m[$urandom_range(8, 15)] = 1'b1;
         end
         add(len, m);
      end
      add(3, 16'h0000);
      do_reset();
      foreach (seq[i]) begin
         run_frame(seq[i]);
         total++;
         if (o_valid !== e_valid || o_extra != 0) begin
            bad++; $display("FAIL random_valid f=%0d got=%b+%0d want=%b+0", i, o_valid, o_extra, e_valid);
         end
         total++;
         if (o_held !== e_held) begin bad++; $display("FAIL random_held f=%0d got=%b want=%b", i, o_held, e_held); end
         total++;
         if (o_code !== e_code) begin bad++; $display("FAIL random_code f=%0d got=%h want=%h", i, o_code, e_code); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_press();
      test_bounce();
      test_multi();
      test_rollover();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
